// File: rtl/register_file_mp.sv
// Multi-read-port register file with byte-enabled writes, optional write-to-read
// bypass, hardwired zero register and a per-register busy scoreboard.
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  reg_wr,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN/8-1:0]     wbe,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    output logic                  busy_any
);

    localparam int NB = XLEN / 8;

    function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_v,
                                                   input logic [XLEN-1:0] new_v,
                                                   input logic [NB-1:0]   be);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[k*8 +: 8] = new_v[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_v[k*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             busy_any_q;
    logic             busy_any_d;
    logic [NREGS-1:0] clr_mask_s;
    logic [NREGS-1:0] set_mask_s;
    logic [XLEN-1:0]  wr_merged_s;
    logic             wr_zero_s;
    logic             set_zero_s;

    // Merged value serves both the array update and the bypass path.
    assign wr_merged_s = byte_merge(regs_q[waddr], wdata, wbe);
    assign wr_zero_s   = (ZERO_REG != 0) && (waddr == {AW{1'b0}});
    assign set_zero_s  = (ZERO_REG != 0) && (sb_addr == {AW{1'b0}});
    assign busy_any    = busy_any_q;

    // Next register contents.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            if (reg_wr && !wr_zero_s && (waddr == AW'(r))) begin
                regs_d[r] = wr_merged_s;
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
    end

    // Next scoreboard state: set is OR-ed after the clear so a new producer wins.
    always_comb begin
        clr_mask_s = {NREGS{1'b0}};
        set_mask_s = {NREGS{1'b0}};
        if (reg_wr) begin
            clr_mask_s = {{(NREGS-1){1'b0}}, 1'b1} << waddr;
        end else begin
            clr_mask_s = {NREGS{1'b0}};
        end
        if (sb_set && !set_zero_s) begin
            set_mask_s = {{(NREGS-1){1'b0}}, 1'b1} << sb_addr;
        end else begin
            set_mask_s = {NREGS{1'b0}};
        end
        busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
        busy_any_d = |busy_d;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
            busy_q     <= {NREGS{1'b0}};
            busy_any_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            busy_any_q <= busy_any_d;
        end
    end

    // Read ports; outputs are forced low during reset so a bypassed write cannot leak.
    always_comb begin : read_ports
        logic [AW-1:0] ra_v;
        logic          hit_v;
        rdata = {(NRD*XLEN){1'b0}};
        rbusy = {NRD{1'b0}};
        ra_v  = {AW{1'b0}};
        hit_v = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            ra_v  = raddr[i*AW +: AW];
            hit_v = (BYPASS != 0) && reg_wr && (waddr == ra_v) && !wr_zero_s;
            if (!rst_n) begin
                rdata[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy[i]              = 1'b0;
            end else if ((ZERO_REG != 0) && (ra_v == {AW{1'b0}})) begin
                rdata[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rbusy[i]              = 1'b0;
            end else if (hit_v) begin
                rdata[i*XLEN +: XLEN] = wr_merged_s;
                rbusy[i]              = 1'b0;
            end else begin
                rdata[i*XLEN +: XLEN] = regs_q[ra_v];
                rbusy[i]              = busy_q[ra_v];
            end
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table, hand-written
// reset/bypass/multi-port sequences and randomized traffic against a reference model.
module tb_register_file_mp;

    localparam int AW = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [19:0]  raddr;
    logic [127:0] rdata;
    logic [3:0]   rbusy;
    logic         reg_wr;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic [3:0]   wbe;
    logic         sb_set;
    logic [4:0]   sb_addr;
    logic         busy_any;
    logic [63:0]  nb_rdata;
    logic [1:0]   nb_rbusy;
    logic         nb_busy_any;

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(4), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(busy_any)
    );

    register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr[9:0]), .rdata(nb_rdata), .rbusy(nb_rbusy),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_any(nb_busy_any)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    typedef struct {
        bit          wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          st;
        logic [4:0]  sa;
        logic [4:0]  ra;
        logic [31:0] erd;
        bit          erb;
        bit          eany;
        string       nm;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] apply_bytes(input logic [31:0] old_v, input logic [31:0] wd,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mask = mask | (32'hFF << (8 * k));
        end
        return (old_v & ~mask) | (wd & mask);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && reg_wr && waddr == a) return apply_bytes(m_reg[a], wdata, wbe);
        return m_reg[a];
    endfunction

    function automatic logic exp_rb(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && reg_wr && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
        m_busy = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reg_wr) begin
            m_busy[waddr] = 1'b0;
            if (waddr != 5'd0) m_reg[waddr] = apply_bytes(m_reg[waddr], wdata, wbe);
        end
        if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
        #1;
    endtask

    task automatic idle();
        reg_wr = 1'b0; waddr = 5'd0; wdata = 32'h0; wbe = 4'h0;
        sb_set = 1'b0; sb_addr = 5'd0;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle();
        reg_wr = 1'b1; waddr = a; wdata = d; wbe = 4'hF;
        tick();
        idle();
    endtask

    task automatic set_busy(input logic [4:0] a);
        idle();
        sb_set = 1'b1; sb_addr = a;
        tick();
        idle();
    endtask

    task automatic chk_ports(input string tag);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s_rd%0d", tag, p), rdata[p*32 +: 32], exp_rd(raddr[p*AW +: AW], 1'b1));
            chk($sformatf("%s_rb%0d", tag, p), rbusy[p], exp_rb(raddr[p*AW +: AW], 1'b1));
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_nbrd%0d", tag, p), nb_rdata[p*32 +: 32], exp_rd(raddr[p*AW +: AW], 1'b0));
            chk($sformatf("%s_nbrb%0d", tag, p), nb_rbusy[p], exp_rb(raddr[p*AW +: AW], 1'b0));
        end
    endtask

    initial begin
        tbl = '{
            '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, "wr_full"},
            '{1'b1, 5'd5, 32'h000000AA, 4'h1, 1'b0, 5'd0, 5'd5, 32'hDEADBEAA, 1'b0, 1'b0, "wr_byte0"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd5, 32'hDEADBEAA, 1'b0, 1'b0, "rd_r5"},
            '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, "wr_r0"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, "rd_r0"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 5'd3, 32'h0,        1'b0, 1'b1, "set_r3"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd3, 32'h0,        1'b1, 1'b1, "busy_r3"},
            '{1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd3, 32'h11223344, 1'b0, 1'b0, "wr_clr_r3"},
            '{1'b1, 5'd3, 32'h55667788, 4'h3, 1'b1, 5'd3, 5'd3, 32'h11227788, 1'b0, 1'b1, "set_wr_r3"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd3, 32'h11227788, 1'b1, 1'b1, "set_wins"},
            '{1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 5'd3, 32'h11227788, 1'b0, 1'b0, "wr_nobe"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, "set_r0"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd9, 5'd9, 32'h0,        1'b0, 1'b1, "set_r9"},
            '{1'b1, 5'd9, 32'h000000AB, 4'h1, 1'b1, 5'd4, 5'd4, 32'h0,        1'b0, 1'b1, "set4_clr9"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd9, 32'h000000AB, 1'b0, 1'b1, "rd_r9"},
            '{1'b0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 5'd4, 32'h0,        1'b1, 1'b1, "rd_r4"}
        };

        rst_n = 1'b0;
        raddr = 20'd0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // Reset state on every register and every port
        for (int a = 0; a < 32; a++) begin
            raddr = {4{a[4:0]}};
            #1;
            chk($sformatf("rst_rd_r%0d", a), rdata, 128'h0);
            chk($sformatf("rst_rb_r%0d", a), rbusy, 4'h0);
        end
        chk("rst_busy_any", busy_any, 1'b0);

        // Directed vector table
        for (int v = 0; v < 16; v++) begin
            reg_wr = tbl[v].wr; waddr = tbl[v].wa; wdata = tbl[v].wd; wbe = tbl[v].be;
            sb_set = tbl[v].st; sb_addr = tbl[v].sa;
            raddr = {15'd0, tbl[v].ra};
            #2;
            chk({tbl[v].nm, "_rd"}, rdata[31:0], tbl[v].erd);
            chk({tbl[v].nm, "_rb"}, rbusy[0], tbl[v].erb);
            tick();
            chk({tbl[v].nm, "_any"}, busy_any, tbl[v].eany);
        end
        idle();

        // Bypass on versus off
        reg_wr = 1'b1; waddr = 5'd7; wdata = 32'h12345678; wbe = 4'hF;
        raddr = {4{5'd7}};
        #2;
        chk("byp_on_same_cycle", rdata[31:0], 32'h12345678);
        chk("byp_off_old_value", nb_rdata[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("byp_off_after_edge", nb_rdata[31:0], 32'h12345678);

        // Asynchronous reset between edges
        write(5'd4, 32'h00000055);
        set_busy(5'd4);
        set_busy(5'd9);
        raddr = {5'd9, 5'd4, 5'd9, 5'd4};
        #1;
        chk("pre_rst_rb", rbusy, 4'hF);
        chk("pre_rst_rd0", rdata[31:0], 32'h00000055);
        reg_wr = 1'b1; waddr = 5'd4; wdata = 32'hFFFFFFFF; wbe = 4'hF;
        sb_set = 1'b1; sb_addr = 5'd5;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_rd", rdata, 128'h0);
        chk("rst_async_rb", rbusy, 4'h0);
        chk("rst_async_any", busy_any, 1'b0);
        chk("rst_async_nbrd", nb_rdata, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_held_rd", rdata, 128'h0);
        idle();
        rst_n = 1'b1;
        model_clear();
        #1;
        raddr = {5'd5, 5'd4, 5'd9, 5'd4};
        #1;
        chk("post_rst_rd", rdata, 128'h0);
        chk("post_rst_rb", rbusy, 4'h0);
        chk("post_rst_any", busy_any, 1'b0);

        // All ports on one register, then independent ports
        write(5'd9, 32'hCAFEF00D);
        write(5'd1, 32'h11111111);
        write(5'd2, 32'h22222222);
        write(5'd3, 32'h33333333);
        raddr = {4{5'd9}};
        #1;
        chk("same_reg_all_ports", rdata, {4{32'hCAFEF00D}});
        raddr = {5'd3, 5'd2, 5'd1, 5'd0};
        #1;
        chk("indep_ports", rdata, {32'h33333333, 32'h22222222, 32'h11111111, 32'h0});

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            reg_wr  = 1'($urandom_range(0, 1));
            waddr   = 5'($urandom_range(0, 7));
            wdata   = $urandom;
            wbe     = 4'($urandom_range(0, 15));
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++) raddr[p*AW +: AW] = 5'($urandom_range(0, 7));
            #2;
            chk_ports("rnd");
            tick();
            chk("rnd_any", busy_any, |m_busy);
            chk("rnd_nb_any", nb_busy_any, |m_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-read-port integer register file, successor to the current two-read/one-write file.
- Adds a configurable number of read ports and width/depth.
- Adds byte-enabled writes on the rising edge, same-cycle write-to-read bypass, an asynchronous clear, and a per-register busy scoreboard.
- Sits between decode (reads, scoreboard set) and the writeback stage (writes, scoreboard clear) of the pipeline.

Parameters:
XLEN, 32, register width in bits; must be a multiple of 8.
NREGS, 32, number of architectural registers; power of two, at least 2.
NRD, 2, number of read ports.
ZERO_REG, 1, when 1 register 0 is hardwired to zero and never marked busy.
BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports and clears the matching busy flags.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
raddr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW], AW = clog2(NREGS)
rdata  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rbusy  out  NRD  busy flag of register addressed by port i
reg_wr  in  1  write enable
waddr  in  AW  write address
wdata  in  XLEN  write data
wbe  in  XLEN/8  byte enables for the write
sb_set  in  1  mark sb_addr busy (instruction issued with destination sb_addr)
sb_addr  in  AW  scoreboard set address
busy_any  out  1  OR of all busy flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers become 0 and all busy flags become 0.
  - rdata is all zero, rbusy is 0 and busy_any is 0 while reset is held.
  - Deassertion is synchronised by the user; no file preload.
- Write:
  - Takes effect at the rising edge when reg_wr=1.
  - Byte k of register[waddr] takes wdata byte k only where wbe[k]=1; other bytes are retained.
  - reg_wr=1 with wbe all 0 changes no data but still clears busy.
  - ZERO_REG=1 and waddr=0: data is discarded and register 0 stays 0.
- Read:
  - Combinational, zero latency: rdata[i] = register[raddr[i]].
  - ZERO_REG=1 and raddr[i]=0: rdata[i]=0 regardless of anything else.
- Bypass (BYPASS=1):
  - If reg_wr=1 and waddr==raddr[i] (and not the zero register), rdata[i] = old value with the enabled bytes replaced by wdata bytes, in the same cycle.
  - BYPASS=0: rdata[i] shows the old value until after the edge.
- Scoreboard, one busy bit per register, updated at the rising edge:
  - set when sb_set=1 at sb_addr.
  - cleared when reg_wr=1 at waddr.
  - Same address set and cleared in the same cycle: set wins (new producer issued).
  - ZERO_REG=1: sb_set to register 0 is ignored.
  - Set of register A and clear of register B in the same cycle: both apply.
- rbusy and busy_any:
  - rbusy[i] = busy[raddr[i]].
  - With BYPASS=1, rbusy[i] is forced 0 when reg_wr=1 and waddr==raddr[i] in that cycle, even if the bit is only cleared at the edge.
  - busy_any is the registered OR of the busy bits (reflects state after the last edge).
- Reset asserted mid-operation: pending write and set are lost; all state is zero immediately, without waiting for a clock.
- All read ports are independent. Any number of ports may address the same register with identical results.

Test Plan:
1. Reset, then read all registers on every port -> rdata=0, rbusy=0, busy_any=0.
2. Write 0xDEADBEEF to r5 with wbe=4'b1111, then write 0x000000AA with wbe=4'b0001 -> r5 reads 0xDEADBEAA; a write to r0 of 0xFFFFFFFF -> r0 reads 0.
3. BYPASS=1: in the same cycle reg_wr=1, waddr=7, wdata=0x12345678, raddr[0]=7 -> rdata[0]=0x12345678 before the edge. BYPASS=0 -> old value shown until after the edge.
4. sb_set r3, next cycle raddr[1]=3 -> rbusy[1]=1 and busy_any=1. Write r3 -> rbusy[1]=0 in the write cycle, and busy_any=0 after the edge. sb_set r3 together with a write to r3 in one cycle -> r3 remains busy.
5. Busy r4, r9 and data 0x55 in r4, then pull rst_n low between clock edges -> immediate rdata=0, rbusy=0, busy_any=0.
6. NRD=4, all ports raddr=9 after writing 0xCAFEF00D -> all four rdata equal 0xCAFEF00D; ports 0..3 at r0, r1, r2, r3 return independent values.
